// File: rtl/sha256_feeder_if.sv
// sha256_feeder_if: byte stream, hash core and digest handshakes
// bundled for the sha256 feeder stage.
interface sha256_feeder_if;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic             sha_in_valid;
  logic [31:0][7:0] sha_in_data;
  logic             sha_out_valid;
  logic [31:0][7:0] sha_out_res;
  logic             res_valid;
  logic [31:0][7:0] res_data;
  logic             res_ready;

  modport slave (
    input  s_valid, s_data, sha_out_valid,
    input  sha_out_res, res_ready,
    output s_ready, sha_in_valid, sha_in_data,
    output res_valid, res_data
  );

  modport master (
    output s_valid, s_data, sha_out_valid,
    output sha_out_res, res_ready,
    input  s_ready, sha_in_valid, sha_in_data,
    input  res_valid, res_data
  );
endinterface

// File: rtl/sha256_feeder.sv
// sha256_feeder: packs a 32-byte stream for the sha256 core and
// holds the returned digest under a valid/ready handshake.
module sha256_feeder #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  sha256_feeder_if.slave bus,
  output logic           err,
  output logic [15:0]    blocks_done
);

  typedef enum logic [1:0] {
    FILL, ISSUE, WAIT, HOLD
  } state_e;

  localparam logic [15:0] WLAST = 16'(TIMEOUT - 2);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             armed_q, armed_d;
  logic             s_ready_q, s_ready_d;
  logic             in_valid_q, in_valid_d;
  logic [31:0][7:0] in_data_q, in_data_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0][7:0] res_data_q, res_data_d;
  logic             err_q, err_d;
  logic [15:0]      done_q, done_d;

  logic       take;
  logic       capture;
  logic       expire;
  logic [4:0] widx;

  // byte k lands at 4*(k/4)+3-(k%4): big-endian words
  always_comb begin
    take    = (state_q == FILL) && s_ready_q
              && bus.s_valid;
    capture = (state_q == WAIT) && armed_q
              && bus.sha_out_valid;
    expire  = (state_q == WAIT) && !capture
              && (wcnt_q == WLAST);
    widx    = {cnt_q[4:2], ~cnt_q[1:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      armed_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      armed_q     <= armed_d;
      s_ready_q   <= s_ready_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:
        if (take && (cnt_q == 5'd31))
          state_d = ISSUE;
      ISSUE:
        state_d = WAIT;
      WAIT:
        if (capture)
          state_d = HOLD;
        else if (expire)
          state_d = FILL;
      HOLD:
        if (bus.res_ready)
          state_d = FILL;
      default:
        state_d = FILL;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    armed_d    = armed_q;
    in_data_d  = in_data_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    done_d     = done_q;
    if (take) begin
      cnt_d           = cnt_q + 5'd1;
      in_data_d[widx] = bus.s_data;
    end
    unique case (state_q)
      ISSUE: begin
        wcnt_d  = '0;
        armed_d = 1'b0;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 16'd1;
        // a level still high from the last block must not count
        if (!bus.sha_out_valid)
          armed_d = 1'b1;
        if (capture)
          res_data_d = bus.sha_out_res;
        if (expire)
          err_d = 1'b1;
      end
      HOLD:
        if (bus.res_ready)
          done_d = done_q + 16'd1;
      default: ;
    endcase
    s_ready_d   = (state_d == FILL);
    in_valid_d  = (state_d == ISSUE);
    res_valid_d = (state_d == HOLD);
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.sha_in_valid = in_valid_q;
  assign bus.sha_in_data  = in_data_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign err              = err_q;
  assign blocks_done      = done_q;

endmodule

// File: tb/tb_sha256_feeder.sv
// tb_sha256_feeder: directed vectors for the sha256 feeder,
// hash core replaced by a scripted stub.
module tb_sha256_feeder;
  logic        clk;
  logic        rst;
  logic        err;
  logic [15:0] blocks_done;

  sha256_feeder_if bus();

  sha256_feeder #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err         (err),
    .blocks_done (blocks_done)
  );

  localparam logic [255:0] DIG0 =
    256'h66687aad_f862bd77_6c8fc18b_8e9f8e20_08971485_6ee233b3_902a591d_0d5f2925;
  localparam logic [255:0] SEQ =
    256'h1c1d1e1f_18191a1b_14151617_10111213_0c0d0e0f_08090a0b_04050607_00010203;
  localparam logic [255:0] ALL_AA = {32{8'hAA}};
  localparam logic [255:0] ALL_55 = {32{8'h55}};
  localparam logic [255:0] ALL_33 = {32{8'h33}};

  int          n_chk;
  int          n_fail;
  logic [7:0]  msg [32];
  logic [15:0] exp_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = msg[i];
      for (int w = 0; w < 40 && !bus.s_ready; w++)
        tick();
      chk("s_ready_fill", bus.s_ready, 1);
      tick();
      chk("in_valid_pulse", bus.sha_in_valid, (i == 31));
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic accept(input logic [255:0] d);
    chk("hold_data", bus.res_data, d);
    chk("hold_s_ready", bus.s_ready, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    exp_done++;
    chk("blocks_done", blocks_done, exp_done);
    chk("res_valid_fall", bus.res_valid, 0);
    chk("s_ready_rise", bus.s_ready, 1);
  endtask

  task automatic deliver(input logic [255:0] d);
    bus.sha_out_valid = 1'b0;
    tick();
    chk("in_valid_fall", bus.sha_in_valid, 0);
    tick();
    bus.sha_out_valid = 1'b1;
    bus.sha_out_res   = d;
    for (int w = 0; w < 20 && !bus.res_valid; w++)
      tick();
    chk("res_valid_rise", bus.res_valid, 1);
    bus.sha_out_valid = 1'b0;
    accept(d);
  endtask

  task automatic chk_reset();
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_in_valid", bus.sha_in_valid, 0);
    chk("rst_in_data", bus.sha_in_data, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_blocks", blocks_done, 0);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    exp_done = '0;
    rst               = 1'b0;
    bus.s_valid       = 1'b0;
    bus.s_data        = '0;
    bus.sha_out_valid = 1'b0;
    bus.sha_out_res   = '0;
    bus.res_ready     = 1'b0;
    tick();
    tick();
    chk_reset();
    rst = 1'b1;
    tick();
    chk("s_ready_after_rst", bus.s_ready, 1);

    // ascending bytes: layout and single issue pulse
    for (int i = 0; i < 32; i++) msg[i] = 8'(i);
    send(32);
    chk("byte3", bus.sha_in_data[3], 8'h00);
    chk("byte0", bus.sha_in_data[0], 8'h03);
    chk("byte7", bus.sha_in_data[7], 8'h04);
    chk("byte28", bus.sha_in_data[28], 8'h1F);
    chk("seq_block", bus.sha_in_data, SEQ);
    chk("issue_s_ready", bus.s_ready, 0);
    deliver(256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0);

    // zero message, known digest
    for (int i = 0; i < 32; i++) msg[i] = 8'h00;
    send(32);
    chk("zero_block", bus.sha_in_data, 0);
    deliver(DIG0);

    // stale high out_valid must be ignored
    bus.sha_out_valid = 1'b1;
    bus.sha_out_res   = ALL_55;
    for (int i = 0; i < 32; i++) msg[i] = 8'hA0 + 8'(i);
    send(32);
    tick();
    chk("stale_wait0", bus.res_valid, 0);
    tick();
    chk("stale_wait1", bus.res_valid, 0);
    bus.sha_out_valid = 1'b0;
    bus.sha_out_res   = ALL_AA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stale_low", bus.res_valid, 0);
    end
    bus.sha_out_valid = 1'b1;
    tick();
    bus.sha_out_valid = 1'b0;
    chk("stale_capture", bus.res_valid, 1);
    chk("stale_data", bus.res_data, ALL_AA);

    // held digest with back-pressure and s_valid high
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_s_ready", bus.s_ready, 0);
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_data", bus.res_data, ALL_AA);
      chk("bp_blocks", blocks_done, exp_done);
    end
    bus.s_valid = 1'b0;
    accept(ALL_AA);

    // capture on the same edge as the timeout
    for (int i = 0; i < 32; i++) msg[i] = 8'(3 * i);
    send(32);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("race_wait", bus.res_valid, 0);
    end
    bus.sha_out_valid = 1'b1;
    bus.sha_out_res   = ALL_33;
    tick();
    bus.sha_out_valid = 1'b0;
    chk("race_capture", bus.res_valid, 1);
    chk("race_err", err, 0);
    accept(ALL_33);

    // timeout: stub never answers
    for (int i = 0; i < 32; i++) msg[i] = 8'hFF - 8'(i);
    send(32);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_err_low", err, 0);
      chk("to_res_valid", bus.res_valid, 0);
    end
    tick();
    chk("to_err", err, 1);
    chk("to_fill", bus.s_ready, 1);
    chk("to_res_valid_end", bus.res_valid, 0);
    chk("to_blocks", blocks_done, exp_done);
    chk("to_res_data", bus.res_data, ALL_33);
    for (int i = 0; i < 32; i++) msg[i] = 8'(i) ^ 8'h5A;
    send(32);
    deliver(256'hc0ffee00_11223344_55667788_99aabbcc_ddeeff00_13579bdf_2468ace0_deadbeef);
    chk("to_err_sticky", err, 1);

    // reset after a partial block
    for (int i = 0; i < 32; i++) msg[i] = 8'h40 + 8'(i);
    send(17);
    rst = 1'b0;
    #1;
    chk_reset();
    exp_done = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("rerst_s_ready", bus.s_ready, 1);
    for (int i = 0; i < 32; i++) msg[i] = 8'h80 + 8'(i);
    send(32);
    chk("rerst_byte3", bus.sha_in_data[3], 8'h80);
    chk("rerst_byte28", bus.sha_in_data[28], 8'h9F);
    tick();
    chk("rerst_pulse_end", bus.sha_in_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
